// File: rtl/serial_comparator_nb.sv
// ---------------------------------------------------------------------------
// serial_comparator_nb
//
// Purpose:
//   Bit-serial magnitude comparator with early termination. Operands are
//   captured on start and examined one bit pair per cycle, MSB first. The
//   first differing pair decides the result. If no pair differs, the
//   operands are equal. Signed (two's-complement) compares invert the
//   decision only when the MSB pair differs.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous, active-high reset
//   start        - begin a comparison (accepted only while idle)
//   signed_mode  - 0 unsigned, 1 two's-complement (captured with start)
//   A, B         - operands (captured with start)
//   busy         - high while a comparison is in flight or just finished
//   done         - one-cycle pulse, results valid in that cycle
//   A_great_B    - registered result A > B
//   A_equal_B    - registered result A == B
//   A_less_B     - registered result A < B
// ---------------------------------------------------------------------------
module serial_comparator_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_great_B,
  output logic             A_equal_B,
  output logic             A_less_B
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_at_msb;
  logic             w_at_lsb;
  logic             w_load;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  // Shift-based bit select keeps the index width legal even when WIDTH is 1.
  assign w_a_shift = r_a >> r_idx;
  assign w_b_shift = r_b >> r_idx;
  assign w_bit_a   = w_a_shift[0];
  assign w_bit_b   = w_b_shift[0];
  assign w_at_msb  = (r_idx == IDX_W'(WIDTH - 1));
  assign w_at_lsb  = (r_idx == {IDX_W{1'b0}});

  // Next-state and result decode for the current bit pair.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_gt        = 1'b0;
    w_eq        = 1'b0;
    w_lt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COMPARE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (w_bit_a != w_bit_b) begin
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
          // Only a differing sign bit flips the decision in signed mode.
          if (r_signed && w_at_msb) begin
            w_gt = w_bit_b;
            w_lt = w_bit_a;
          end else begin
            w_gt = w_bit_a;
            w_lt = w_bit_b;
          end
        end else if (w_at_lsb) begin
          w_load      = 1'b1;
          w_eq        = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_COMPARE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand capture, bit index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_signed <= 1'b0;
      r_idx    <= {IDX_W{1'b0}};
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_a      <= A;
        r_b      <= B;
        r_signed <= signed_mode;
        r_idx    <= IDX_W'(WIDTH - 1);
      end else if (r_state == S_COMPARE) begin
        // Wraps after the last bit; the value is unused until the next start.
        r_idx <= r_idx - IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end
      if (w_load) begin
        r_gt <= w_gt;
        r_eq <= w_eq;
        r_lt <= w_lt;
      end else begin
        r_gt <= r_gt;
        r_eq <= r_eq;
        r_lt <= r_lt;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign A_great_B = r_gt;
  assign A_equal_B = r_eq;
  assign A_less_B  = r_lt;

endmodule

// File: tb/tb_serial_comparator_nb.sv
// ---------------------------------------------------------------------------
// tb_serial_comparator_nb
//
// Purpose:
//   Self-checking bench for serial_comparator_nb. It uses an 8-bit instance
//   and a 1-bit instance that share the reset. Expected results come from
//   integer compares. The expected cycle count comes from the position of the
//   highest differing bit.
// ---------------------------------------------------------------------------
module tb_serial_comparator_nb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sm;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  logic         start1;
  logic         sm1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         busy1;
  logic         done1;
  logic         gt1;
  logic         eq1;
  logic         lt1;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [2:0]   prev_res;
  logic [2:0]   prev_res1;

  always #5 clk = ~clk;

  serial_comparator_nb #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .A(a), .B(b),
    .busy(busy), .done(done), .A_great_B(gt), .A_equal_B(eq), .A_less_B(lt)
  );

  serial_comparator_nb #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .A_great_B(gt1), .A_equal_B(eq1), .A_less_B(lt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer compare plus the position of the highest differing bit.
  function automatic void model8(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [2:0] res, output int k);
    int xv;
    int yv;
    if (s) begin
      xv = $signed(x);
      yv = $signed(y);
    end else begin
      xv = int'(x);
      yv = int'(y);
    end
    res = (xv > yv) ? 3'b100 : ((xv == yv) ? 3'b010 : 3'b001);
    k = W;
    for (int i = 0; i < W; i++) begin
      if (x[i] != y[i]) k = W - i;
    end
  endfunction

  // One 8-bit comparison. rst_at > 0 aborts with reset asserted at edge t0+rst_at.
  task automatic run8(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input bit disturb, input int rst_at);
    logic [2:0] exp;
    int         k;
    model8(x, y, s, exp, k);
    @(negedge clk);
    a = x; b = y; sm = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= W + 1; c++) begin
      if (rst_at > 0 && c == rst_at) begin
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_res", {gt, eq, lt}, 3'b000);
        rst = 1'b0;
        prev_res = 3'b000;
        prev_res1 = 3'b000;
        return;
      end
      if (c < k) begin
        chk("cmp_busy", busy, 1'b1);
        chk("cmp_done", done, 1'b0);
        chk("cmp_hold", {gt, eq, lt}, prev_res);
      end else if (c == k) begin
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("result", {gt, eq, lt}, exp);
      end else begin
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_res", {gt, eq, lt}, exp);
        prev_res = exp;
        return;
      end
      // Inputs wiggle while busy. None of it may reach the comparison in flight.
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); sm = 1'($urandom); start = 1'($urandom);
      end
      if (rst_at > 0 && c == rst_at - 1) begin
        rst = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // One 1-bit comparison. In signed mode the operand value 1 means -1.
  task automatic run1(input logic x, input logic y, input logic s);
    logic [2:0] exp;
    int xv;
    int yv;
    xv = s ? -int'(x) : int'(x);
    yv = s ? -int'(y) : int'(y);
    exp = (xv > yv) ? 3'b100 : ((xv == yv) ? 3'b010 : 3'b001);
    @(negedge clk);
    a1 = x; b1 = y; sm1 = s; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    chk("w1_hold", {gt1, eq1, lt1}, prev_res1);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_res", {gt1, eq1, lt1}, exp);
    @(negedge clk);
    chk("w1_post", {done1, busy1}, 2'b00);
    prev_res1 = exp;
  endtask

  initial begin
    int k;
    logic [2:0] r;
    rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    prev_res = 3'b000; prev_res1 = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_res", {gt, eq, lt}, 3'b000);
    chk("reset_res1", {gt1, eq1, lt1}, 3'b000);
    rst = 1'b0;
    // With start low the block stays idle.
    repeat (3) begin
      @(negedge clk);
      chk("idle_stay", {busy, done}, 2'b00);
    end

    run8(8'hA5, 8'hA5, 1'b0, 1'b0, 0);
    run8(8'h80, 8'h7F, 1'b0, 1'b0, 0);
    run8(8'h80, 8'h7F, 1'b1, 1'b0, 0);
    run8(8'h12, 8'h13, 1'b0, 1'b0, 0);
    run8(8'h01, 8'h00, 1'b0, 1'b1, 0);
    run8(8'h00, 8'h01, 1'b0, 1'b0, 4);
    run8(8'h00, 8'h01, 1'b0, 1'b0, 0);
    run8(8'h7F, 8'hFF, 1'b1, 1'b1, 0);
    run8(8'hFE, 8'hFF, 1'b1, 1'b0, 0);

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 4; v++) begin
        run1(1'(v >> 1), 1'(v), 1'(s));
      end
    end

    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      // Often share high bits so that long compares are common.
      y = ($urandom_range(0, 2) == 0) ? W'($urandom) : (x ^ W'(1 << $urandom_range(0, W - 1)));
      if ($urandom_range(0, 9) == 0) y = x;
      model8(x, y, 1'b0, r, k);
      if (k > 1 && $urandom_range(0, 7) == 0) begin
        run8(x, y, 1'($urandom), 1'b1, $urandom_range(1, k - 1));
      end else begin
        run8(x, y, 1'($urandom), 1'($urandom), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
